// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven by decode into muldiv_unit.op
//   - FSM state encoding
//   - helper to classify an op as an iterative mul/div
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIN  = 2'd2
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU occupy the low half of the encoding space.
  function automatic logic mdu_is_md(logic [2:0] op);
    return op <= 3'd3;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-divide step.
//   rem_in  : partial remainder (always < divisor)
//   in_bit  : next dividend bit shifted into the remainder
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, in_bit};
    diff    = shifted - {1'b0, divisor};
    // rem_in < divisor keeps shifted - divisor below 2^WIDTH when it does
    // not borrow, so the top bit of diff is exactly the borrow.
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide with HI/LO
// registers for the execute stage.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : abort any in-flight op, highest priority
//   valid, op  : md op present in execute and its mdu_pkg encoding
//   srca, srcb : rs / rt operands
//   hi, lo     : architectural HI/LO registers
//   stall      : hold F/D/E while an op is accepted or iterating
//   busy       : registered, high while iterating
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             busy
);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // {remainder|product hi, dividend/quotient|multiplier}
  logic [WIDTH-1:0]     opnd_q, opnd_d; // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;   // product / quotient sign
  logic                 rneg_q, rneg_d; // remainder sign
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d;

  logic                 is_md, is_divop, signed_op, divzero;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod_fix;
  logic [WIDTH-1:0]     div_rem;
  logic                 div_q;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
    .in_bit  (acc_q[WIDTH-1]),
    .divisor (opnd_q),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  always_comb begin
    is_md     = mdu_is_md(op);
    is_divop  = (op == MDU_DIV) || (op == MDU_DIVU);
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    divzero   = is_divop && (srcb == '0);
    abs_a     = (signed_op && srca[WIDTH-1]) ? -srca : srca;
    abs_b     = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;

    // Multiply: add multiplicand when the multiplier LSB is set, shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: dividend bits leave the top of the low half as quotient bits enter.
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_q};
    step_next = is_div_q ? div_next : mul_next;

    prod_fix  = neg_q  ? -step_next : step_next;
    quot_fix  = neg_q  ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem_fix   = rneg_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid && is_md) begin
            if (divzero) begin
              hi_d    = srca;
              lo_d    = '1;
              state_d = S_FIN;
            end else begin
              acc_d    = {{WIDTH{1'b0}}, is_divop ? abs_a : abs_b};
              opnd_d   = is_divop ? abs_b : abs_a;
              is_div_d = is_divop;
              neg_d    = signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
              rneg_d   = signed_op && is_divop && srca[WIDTH-1];
              cnt_d    = CNT_W'(WIDTH);
              state_d  = S_BUSY;
            end
          end else if (valid && op == MDU_MTHI) begin
            hi_d = srca;
          end else if (valid && op == MDU_MTLO) begin
            lo_d = srca;
          end
        end
        S_BUSY: begin
          acc_d = step_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quot_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
            state_d = S_FIN;
          end
        end
        // The accepted instruction is still in execute here; do not re-accept it.
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  // A divide-by-zero still stalls its accept cycle so the instruction is
  // held in execute through FIN, where it is ignored, and retires once.
  assign stall = !flush && (((state_q == S_IDLE) && valid && is_md) || (state_q == S_BUSY));
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit (WIDTH=32)
// plus a few directed WIDTH=8 checks on a second instance.
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srca = '0, srcb = '0;
  logic [31:0] hi, lo;
  logic        stall, busy;

  logic        valid8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  srca8 = '0, srcb8 = '0;
  logic [7:0]  hi8, lo8;
  logic        stall8, busy8;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          sc;
    bit          mt;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mhi = '0, mlo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid(valid), .op(op),
    .srca(srca), .srcb(srcb), .hi(hi), .lo(lo), .stall(stall), .busy(busy)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(1'b0), .valid(valid8), .op(op8),
    .srca(srca8), .srcb(srcb8), .hi(hi8), .lo(lo8), .stall(stall8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output exp_t e);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.sc = 33;
    e.mt = 1'b0;
    case (o)
      MDU_MULT:  begin p = 64'(sa * sb); {mhi, mlo} = p; end
      MDU_MULTU: begin p = ua * ub;      {mhi, mlo} = p; end
      MDU_DIV:
        if (b == 0) begin mhi = a; mlo = '1; e.sc = 1; end
        else begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      MDU_DIVU:
        if (b == 0) begin mhi = a; mlo = '1; e.sc = 1; end
        else begin mlo = 32'(ua / ub); mhi = 32'(ua % ub); end
      MDU_MTHI: begin mhi = a; e.sc = 0; e.mt = 1'b1; end
      default:  begin mlo = a; e.sc = 0; e.mt = 1'b1; end
    endcase
    e.hi = mhi;
    e.lo = mlo;
  endfunction

  // Behaves like the pipeline: the op sits in execute until stall drops.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    bit   st;
    model(o, a, b, e);
    sbq.push_back(e);
    valid = 1'b1; op = o; srca = a; srcb = b;
    n = 0;
    do begin
      @(negedge clk); st = stall;
      @(posedge clk); #1; n++;
    end while (st && n < 100);
    if (st) begin
      tests++; fails++;
      $display("FAIL issue_timeout: stall still %b after %0d cycles, required 0", st, n);
    end
    valid = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, output int sc);
    int n;
    bit st;
    valid8 = 1'b1; op8 = o; srca8 = a; srcb8 = b;
    n = 0; sc = 0;
    do begin
      @(negedge clk); st = stall8; if (st) sc++;
      @(posedge clk); #1; n++;
    end while (st && n < 50);
    valid8 = 1'b0;
  endtask

  // Monitor: counts stall cycles of the op in execute and checks on retire.
  initial begin
    int          scnt;
    bit          pend;
    logic [31:0] ph, pl;
    exp_t        e;
    scnt = 0; pend = 1'b0; ph = '0; pl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0; pend = 1'b0;
      end else begin
        if (pend) begin
          check("mt_hi", {32'b0, hi}, {32'b0, ph});
          check("mt_lo", {32'b0, lo}, {32'b0, pl});
          pend = 1'b0;
        end
        if (flush) begin
          check("flush_stall", {63'b0, stall}, 64'd0);
          scnt = 0;
        end else if (valid) begin
          if (stall) scnt++;
          else begin
            if (sbq.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_retire: op %0d retired with empty scoreboard", op);
            end else begin
              e = sbq.pop_front();
              check("stall_cycles", 64'(scnt), 64'(e.sc));
              if (e.mt) begin
                pend = 1'b1; ph = e.hi; pl = e.lo;
              end else begin
                check("hi", {32'b0, hi}, {32'b0, e.hi});
                check("lo", {32'b0, lo}, {32'b0, e.lo});
              end
            end
            scnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sc;
    logic [31:0] a, b;
    logic [2:0]  o;
    logic [31:0] flush_a;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_stall_busy", {62'b0, stall, busy}, 64'd0);
    check("rst_w8", {46'b0, hi8, lo8, stall8, busy8}, 64'd0);
    @(posedge clk); #1;

    // Directed cases
    issue(MDU_DIV,  32'hFFFF_FFF9, 32'd2);         // -7 / 2
    issue(MDU_MULT, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(MDU_DIVU, 32'hFFFF_FFFF, 32'h10);        // back-to-back after FIN
    issue(MDU_DIVU, 32'd123, 32'd0);
    issue(MDU_MTHI, 32'h1234, 32'd0);
    issue(MDU_MTLO, 32'h5678, 32'd0);
    issue(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF); // MIN_INT / -1
    issue(MDU_DIV,  32'd5, 32'd0);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush on the 10th BUSY cycle
    issue(MDU_MTHI, 32'hAAAA, 32'd0);
    issue(MDU_MTLO, 32'h5555, 32'd0);
    flush_a = $urandom;
    valid = 1'b1; op = MDU_DIV; srca = flush_a; srcb = 32'd3;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("flush_idle", {62'b0, stall, busy}, 64'd0);
    check("flush_hilo", {hi, lo}, {32'hAAAA, 32'h5555});
    @(posedge clk); #1;

    // Random ops with biased operands
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      issue(o, a, b);
    end

    // Reset during BUSY
    valid = 1'b1; op = MDU_MULTU; srca = 32'hDEAD_BEEF; srcb = 32'h1234_5678;
    repeat (5) begin @(posedge clk); #1; end
    valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mhi = '0; mlo = '0;
    @(negedge clk);
    check("rst_busy_hilo", {hi, lo}, 64'd0);
    check("rst_busy_flags", {62'b0, stall, busy}, 64'd0);
    @(posedge clk); #1;
    issue(MDU_DIV, 32'hFFFF_FF00, 32'h0000_0007);

    // WIDTH=8 instance
    issue8(MDU_MULTU, 8'hFF, 8'hFF, sc);
    check("w8_multu", {48'b0, hi8, lo8}, 64'hFE01);
    check("w8_multu_stall", 64'(sc), 64'd9);
    issue8(MDU_DIV, 8'h80, 8'hFF, sc);
    check("w8_div_minint", {48'b0, hi8, lo8}, 64'h0080);
    issue8(MDU_DIV, 8'hF9, 8'h02, sc);
    check("w8_div_neg", {48'b0, hi8, lo8}, 64'hFFFD);
    check("w8_div_stall", 64'(sc), 64'd9);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
